// File: rtl/invsqrt_pkg.sv
// Shared definitions for the inverse-square-root datapath: float field
// layout, the constants used by the Newton refinement and FSM encoding.
package invsqrt_pkg;

    // Positive-only float: [30:23] biased exponent, [22:0] mantissa (hidden 1)
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int FLT_W = 31;
    localparam int BIAS  = 127;

    localparam logic [FLT_W-1:0] THREE_HALVES = 31'h3FC00000;
    localparam logic [FLT_W-1:0] FLT_MAX      = 31'h7F7FFFFF;

    // Mantissa of 1.5 with the hidden bit at position 23
    localparam logic [MAN_W:0] THREE_HALVES_MAN = 24'hC00000;

    // Newton FSM encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MUL_YY = 3'd1;
    localparam logic [2:0] ST_MUL_X2 = 3'd2;
    localparam logic [2:0] ST_SUB    = 3'd3;
    localparam logic [2:0] ST_MUL_Y  = 3'd4;

    typedef logic [FLT_W-1:0] flt_t;

    // Assemble a float from its exponent and mantissa fields
    function automatic flt_t fp_pack(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        return {e, m};
    endfunction

endpackage

// File: rtl/fp31_mul.sv
// Combinational multiply of two positive 31-bit floats. Mantissa is
// truncated; zero-exponent operands and underflow flush to 0, overflow
// saturates to the largest finite value.
module fp31_mul
    import invsqrt_pkg::*;
(
    input  logic [FLT_W-1:0] a,
    input  logic [FLT_W-1:0] b,
    output logic [FLT_W-1:0] p
);

    logic [MAN_W:0]       man_a;
    logic [MAN_W:0]       man_b;
    logic [2*MAN_W+1:0]   prod;
    logic [MAN_W-1:0]     man_p;
    logic signed [10:0]   exp_sum;
    logic                 unused_lsbs;

    // Full 24x24 mantissa product, normalised by its top bit
    always_comb begin
        man_a   = {1'b1, a[MAN_W-1:0]};
        man_b   = {1'b1, b[MAN_W-1:0]};
        prod    = {24'd0, man_a} * {24'd0, man_b};
        man_p   = prod[47] ? prod[46:24] : prod[45:23];
        exp_sum = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]})
                - 11'sd127 + $signed({10'd0, prod[47]});
    end

    // Low product bits fall off the truncated mantissa
    assign unused_lsbs = ^prod[22:0];

    // Special-case selection: flush, underflow, saturate, normal
    always_comb begin
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            p = '0;
        end else if (exp_sum <= 11'sd0) begin
            p = '0;
        end else if (exp_sum >= 11'sd255) begin
            p = FLT_MAX;
        end else begin
            p = fp_pack(exp_sum[7:0], man_p);
        end
    end

endmodule

// File: rtl/invsqrt_pipe_newton.sv
// Newton-Raphson refinement of an inverse-square-root estimate.
// One shared multiplier is time-multiplexed over four FSM states per
// iteration: y <- y * (1.5 - x2*y*y). in_ready is high only when idle.
module invsqrt_pipe_newton
    import invsqrt_pkg::*;
#(
    parameter int ITERATIONS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [FLT_W-1:0] x2,
    input  logic [FLT_W-1:0] y,
    output logic             in_ready,
    output logic [FLT_W-1:0] result,
    output logic             out_valid,
    output logic [7:0]       drop_cnt
);

    // Counter only has to distinguish "last step" from "one more step"
    localparam logic ITER_INIT = (ITERATIONS == 2) ? 1'b1 : 1'b0;

    logic [2:0]       state_reg;
    logic [FLT_W-1:0] xr_reg;
    logic [FLT_W-1:0] yr_reg;
    logic [FLT_W-1:0] t_reg;
    logic             iter_reg;
    logic [FLT_W-1:0] result_reg;
    logic             out_valid_reg;
    logic [7:0]       drop_cnt_reg;

    logic [FLT_W-1:0] mul_a;
    logic [FLT_W-1:0] mul_b;
    logic [FLT_W-1:0] mul_p;

    logic [FLT_W-1:0] sub_res;
    logic [EXP_W-1:0] sub_shift;
    logic [MAN_W:0]   sub_aligned;
    logic [MAN_W:0]   sub_diff;
    logic [MAN_W:0]   sub_norm;
    logic [4:0]       sub_lz;
    logic             sub_found;
    logic [EXP_W-1:0] sub_exp;
    logic             unused_hidden;

    assign in_ready  = (state_reg == ST_IDLE);
    assign result    = result_reg;
    assign out_valid = out_valid_reg;
    assign drop_cnt  = drop_cnt_reg;

    // Steer the shared multiplier operands by state
    always_comb begin
        mul_a = yr_reg;
        mul_b = yr_reg;
        case (state_reg)
            ST_MUL_YY: begin
                mul_a = yr_reg;
                mul_b = yr_reg;
            end
            ST_MUL_X2: begin
                mul_a = xr_reg;
                mul_b = t_reg;
            end
            ST_MUL_Y: begin
                mul_a = yr_reg;
                mul_b = t_reg;
            end
            default: begin
                mul_a = yr_reg;
                mul_b = yr_reg;
            end
        endcase
    end

    fp31_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // 1.5 - t: align t to exponent 127, subtract, renormalise
    always_comb begin
        sub_res     = THREE_HALVES;
        sub_shift   = 8'd127 - t_reg[30:23];
        sub_aligned = '0;
        sub_diff    = '0;
        sub_norm    = '0;
        sub_lz      = '0;
        sub_found   = 1'b0;
        sub_exp     = '0;
        if (t_reg[30:23] == 8'd0) begin
            sub_res = THREE_HALVES;
        end else if (t_reg >= THREE_HALVES) begin
            sub_res = '0;
        end else if (sub_shift >= 8'd25) begin
            sub_res = THREE_HALVES;
        end else begin
            sub_aligned = {1'b1, t_reg[MAN_W-1:0]} >> sub_shift;
            sub_diff    = THREE_HALVES_MAN - sub_aligned;
            for (int i = MAN_W; i >= 0; i--) begin
                if (!sub_found) begin
                    if (sub_diff[i]) begin
                        sub_found = 1'b1;
                    end else begin
                        sub_lz = sub_lz + 5'd1;
                    end
                end
            end
            sub_norm = sub_diff << sub_lz;
            sub_exp  = 8'd127 - {3'b000, sub_lz};
            sub_res  = fp_pack(sub_exp, sub_norm[MAN_W-1:0]);
        end
    end

    // The normalised hidden bit is implied by the exponent
    assign unused_hidden = sub_norm[MAN_W];

    // Newton FSM: accept, three arithmetic steps, then update y or finish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            xr_reg        <= '0;
            yr_reg        <= '0;
            t_reg         <= '0;
            iter_reg      <= 1'b0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        xr_reg    <= x2;
                        yr_reg    <= y;
                        iter_reg  <= ITER_INIT;
                        state_reg <= ST_MUL_YY;
                    end
                end
                ST_MUL_YY: begin
                    t_reg     <= mul_p;
                    state_reg <= ST_MUL_X2;
                end
                ST_MUL_X2: begin
                    t_reg     <= mul_p;
                    state_reg <= ST_SUB;
                end
                ST_SUB: begin
                    t_reg     <= sub_res;
                    state_reg <= ST_MUL_Y;
                end
                ST_MUL_Y: begin
                    yr_reg <= mul_p;
                    if (iter_reg != 1'b0) begin
                        iter_reg  <= iter_reg - 1'b1;
                        state_reg <= ST_MUL_YY;
                    end else begin
                        result_reg    <= mul_p;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Count operands offered while busy, saturating at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (in_valid && (state_reg != ST_IDLE) && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

endmodule
